alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL derive localparam SHW = $clog2(WIDTH), shift-amount width.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 alu_op  input  6  operation code, shared ALU_OP_* encoding.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 shamt  input  SHW  immediate shift/rotate amount.
REQ-010 kill  input  1  synchronous abort of an accepted operation.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out  output  WIDTH  result.
REQ-014 zero, great, overflow, div_zero  output  1 each  result flags.
REQ-015 busy  output  1  iteration in progress.

Function
REQ-016 FSM states: IDLE, CALC, DONE; in_ready=1 only in IDLE; busy=1 only in CALC.
REQ-017 IDLE: accept when in_valid=1; capture a, b, shamt and alu_op; single-cycle ops (add/sub, logic, shifts, rotates, slt/sltu) go to DONE next cycle (latency 1).
REQ-018 MUL/MULU/MUH/MUHU: CALC for exactly WIDTH cycles, radix-2 shift-add on magnitudes, sign-corrected for signed ops; DONE follows (latency WIDTH+1); MUL*/MUH* return the low/high WIDTH bits of the 2*WIDTH product.
REQ-019 DIV/DIVU return the quotient, MOD/MODU the remainder; restoring division, WIDTH CALC cycles; signed remainder takes the sign of a.
REQ-020 Divide by zero: no CALC; DONE next cycle; div_zero=1; quotient all-ones, remainder = a.
REQ-021 Signed DIV/MOD with a = most-negative, b = -1: quotient = most-negative, remainder 0, overflow=1; full iteration latency.
REQ-022 ADD/SUB set overflow on two's-complement overflow; ADDU/SUBU and all other ops set overflow=0.
REQ-023 Shifts use shamt (SLL/SRL/SRA/ROTR) or a[SHW-1:0] (variable forms); SRA/SRAV are arithmetic; ROTR/ROTRV are true rotates with an amount of 0 returning b.
REQ-024 SLT signed, SLTU unsigned compare; result 1 or 0.
REQ-025 Unrecognised alu_op: out=0, all flags 0, latency 1.
REQ-026 zero = (out==0); great = signed out > 0; both are computed from the registered result.
REQ-027 DONE: out_valid=1; out and flags held stable until out_ready=1, then IDLE on the next edge; no new request is accepted in the same cycle.
REQ-028 in_valid is ignored outside IDLE; request operands are not re-sampled after acceptance.
REQ-029 kill=1 in CALC or DONE: IDLE on the next edge, out_valid=0, result discarded; kill in IDLE has no effect and does not block acceptance.

Reset
REQ-030 rst_n=0 forces IDLE immediately, independent of clk, including mid-CALC.
REQ-031 During and after reset: out=0, out_valid=0, zero=1, great=0, overflow=0, div_zero=0, busy=0, in_ready=1 (once rst_n=1); the iteration counter and partial registers are cleared.

Structure
REQ-032 ALU_OP_* codes and FSM state encodings SHALL reside in the shared definitions file common.v.
REQ-033 Iterative multiply/divide datapath SHALL be sub-module mdu_core (WIDTH parameter; start, op, a, b in; done, result, ovf out); alu_iter holds the FSM, handshake and single-cycle ops.

Verification
REQ-034 WIDTH=32, ADD a=7FFFFFFF, b=1 -> out=80000000, overflow=1, out_valid one cycle after acceptance; ADDU same operands -> overflow=0.
REQ-035 MUH a=FFFFFFFF(-1), b=2 -> out=FFFFFFFF after 33 cycles; MULU same operands -> out=FFFFFFFE; busy=1 for exactly 32 cycles.
REQ-036 DIV a=-7, b=2 -> out=FFFFFFFD (-3); MOD -> FFFFFFFF (-1); DIV b=0 -> div_zero=1, out=FFFFFFFF, latency 1.
REQ-037 DIV a=80000000, b=FFFFFFFF -> out=80000000, overflow=1; ROTR b=12345678, shamt=4 -> 81234567.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> out/flags stable, in_ready=0; kill at CALC cycle 10 -> IDLE next edge, no out_valid.
REQ-039 Assert rst_n=0 mid-DIVU between clock edges -> immediate IDLE, out=0, zero=1; next request completes correctly.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// rtl/alu_iter_pkg.sv - shared ALU opcode encodings, FSM states and opcode classifiers
package alu_iter_pkg;

   localparam logic [5:0] ALU_OP_ADD   = 6'd0;
   localparam logic [5:0] ALU_OP_ADDU  = 6'd1;
   localparam logic [5:0] ALU_OP_SUB   = 6'd2;
   localparam logic [5:0] ALU_OP_SUBU  = 6'd3;
   localparam logic [5:0] ALU_OP_AND   = 6'd4;
   localparam logic [5:0] ALU_OP_OR    = 6'd5;
   localparam logic [5:0] ALU_OP_XOR   = 6'd6;
   localparam logic [5:0] ALU_OP_NOR   = 6'd7;
   localparam logic [5:0] ALU_OP_SLL   = 6'd8;
   localparam logic [5:0] ALU_OP_SRL   = 6'd9;
   localparam logic [5:0] ALU_OP_SRA   = 6'd10;
   localparam logic [5:0] ALU_OP_ROTR  = 6'd11;
   localparam logic [5:0] ALU_OP_SLLV  = 6'd12;
   localparam logic [5:0] ALU_OP_SRLV  = 6'd13;
   localparam logic [5:0] ALU_OP_SRAV  = 6'd14;
   localparam logic [5:0] ALU_OP_ROTRV = 6'd15;
   localparam logic [5:0] ALU_OP_SLT   = 6'd16;
   localparam logic [5:0] ALU_OP_SLTU  = 6'd17;
   localparam logic [5:0] ALU_OP_MUL   = 6'd18;
   localparam logic [5:0] ALU_OP_MULU  = 6'd19;
   localparam logic [5:0] ALU_OP_MUH   = 6'd20;
   localparam logic [5:0] ALU_OP_MUHU  = 6'd21;
   localparam logic [5:0] ALU_OP_DIV   = 6'd22;
   localparam logic [5:0] ALU_OP_DIVU  = 6'd23;
   localparam logic [5:0] ALU_OP_MOD   = 6'd24;
   localparam logic [5:0] ALU_OP_MODU  = 6'd25;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_mdu_op(input logic [5:0] op);
      return (op >= ALU_OP_MUL) && (op <= ALU_OP_MODU);
   endfunction

   function automatic logic is_div_op(input logic [5:0] op);
      return (op == ALU_OP_DIV) || (op == ALU_OP_DIVU) ||
             (op == ALU_OP_MOD) || (op == ALU_OP_MODU);
   endfunction

   function automatic logic is_signed_mdu(input logic [5:0] op);
      return (op == ALU_OP_MUL) || (op == ALU_OP_MUH) ||
             (op == ALU_OP_DIV) || (op == ALU_OP_MOD);
   endfunction

endpackage

// File: rtl/alu_iter_mdu_core.sv
// rtl/alu_iter_mdu_core.sv - iterative radix-2 multiply / restoring divide on operand magnitudes
module mdu_core
   import alu_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic             running_q, running_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             div_q, div_d;
   logic             sel_hi_q, sel_hi_d;
   logic             neg_res_q, neg_res_d;
   logic             neg_rem_q, neg_rem_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH+1:0]   div_diff;
   logic [WIDTH-1:0]   acc_step, lo_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               sgn, a_neg, b_neg;

   always_comb begin
      running_d = running_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      sel_hi_d  = sel_hi_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      ovf_d     = ovf_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      dvs_d     = dvs_q;

      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
      div_shift = {acc_q, lo_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, dvs_q};

      if (div_q) begin
         // Keep the trial subtraction only when it did not borrow.
         if (!div_diff[WIDTH+1]) begin
            acc_step = div_diff[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_step = div_shift[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_step = mul_sum[WIDTH:1];
         lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end

      prod_fix = neg_res_q ? -{acc_step, lo_step} : {acc_step, lo_step};
      quo_fix  = neg_res_q ? -lo_step : lo_step;
      rem_fix  = neg_rem_q ? -acc_step : acc_step;

      if (div_q) result = sel_hi_q ? rem_fix : quo_fix;
      else       result = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];

      done = running_q && (cnt_q == SHW'(WIDTH-1));
      ovf  = ovf_q;

      sgn   = is_signed_mdu(op);
      a_neg = sgn && a[WIDTH-1];
      b_neg = sgn && b[WIDTH-1];

      if (start) begin
         running_d = 1'b1;
         cnt_d     = '0;
         div_d     = is_div_op(op);
         sel_hi_d  = (op == ALU_OP_MUH) || (op == ALU_OP_MUHU) ||
                     (op == ALU_OP_MOD) || (op == ALU_OP_MODU);
         neg_res_d = a_neg ^ b_neg;
         neg_rem_d = a_neg;
         ovf_d     = sgn && is_div_op(op) && (a == MOST_NEG) && (b == '1);
         acc_d     = '0;
         lo_d      = a_neg ? -a : a;
         dvs_d     = b_neg ? -b : b;
      end else if (running_q) begin
         acc_d = acc_step;
         lo_d  = lo_step;
         cnt_d = cnt_q + 1'b1;
         if (done) running_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running_q <= 1'b0;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         sel_hi_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ovf_q     <= 1'b0;
         acc_q     <= '0;
         lo_q      <= '0;
         dvs_q     <= '0;
      end else begin
         running_q <= running_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         sel_hi_q  <= sel_hi_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         ovf_q     <= ovf_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         dvs_q     <= dvs_d;
      end
   end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - ALU with single-cycle ops and iterative mul/div behind a valid/ready handshake
module alu_iter
   import alu_iter_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             great,
   output logic             overflow,
   output logic             div_zero,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;

   logic             mdu_start, mdu_done, mdu_ovf;
   logic [WIDTH-1:0] mdu_result;

   logic [WIDTH-1:0]   alu_res, add_res, sub_res;
   logic               alu_ovf, alu_dz;
   logic [SHW-1:0]     shv, rot_amt;
   logic [2*WIDTH-1:0] rot_full;

   mdu_core #(.WIDTH(WIDTH)) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdu_start),
      .op     (alu_op),
      .a      (a),
      .b      (b),
      .done   (mdu_done),
      .result (mdu_result),
      .ovf    (mdu_ovf)
   );

   always_comb begin
      add_res  = a + b;
      sub_res  = a - b;
      shv      = a[SHW-1:0];
      rot_amt  = (alu_op == ALU_OP_ROTRV) ? shv : shamt;
      rot_full = {b, b} >> rot_amt;
      alu_res  = '0;
      alu_ovf  = 1'b0;
      alu_dz   = 1'b0;
      case (alu_op)
         ALU_OP_ADD: begin
            alu_res = add_res;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_OP_ADDU:  alu_res = add_res;
         ALU_OP_SUB: begin
            alu_res = sub_res;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_OP_SUBU:  alu_res = sub_res;
         ALU_OP_AND:   alu_res = a & b;
         ALU_OP_OR:    alu_res = a | b;
         ALU_OP_XOR:   alu_res = a ^ b;
         ALU_OP_NOR:   alu_res = ~(a | b);
         ALU_OP_SLL:   alu_res = b << shamt;
         ALU_OP_SRL:   alu_res = b >> shamt;
         ALU_OP_SRA:   alu_res = $signed(b) >>> shamt;
         ALU_OP_SLLV:  alu_res = b << shv;
         ALU_OP_SRLV:  alu_res = b >> shv;
         ALU_OP_SRAV:  alu_res = $signed(b) >>> shv;
         ALU_OP_ROTR,
         ALU_OP_ROTRV: alu_res = rot_full[WIDTH-1:0];
         ALU_OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, a < b};
         // Only reached for a zero divisor; non-zero divisors iterate in the MDU.
         ALU_OP_DIV,
         ALU_OP_DIVU: begin
            alu_res = '1;
            alu_dz  = 1'b1;
         end
         ALU_OP_MOD,
         ALU_OP_MODU: begin
            alu_res = a;
            alu_dz  = 1'b1;
         end
         default:      alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      dz_d      = dz_q;
      mdu_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (is_mdu_op(alu_op) && !(is_div_op(alu_op) && (b == '0))) begin
                  mdu_start = 1'b1;
                  state_d   = ST_CALC;
               end else begin
                  result_d = alu_res;
                  ovf_d    = alu_ovf;
                  dz_d     = alu_dz;
                  state_d  = ST_DONE;
               end
            end
         end
         ST_CALC: begin
            if (kill) begin
               state_d = ST_IDLE;
            end else if (mdu_done) begin
               result_d = mdu_result;
               ovf_d    = mdu_ovf;
               dz_d     = 1'b0;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (kill || out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_CALC);
   assign out_valid = (state_q == ST_DONE);
   assign out       = result_q;
   assign zero      = (result_q == '0);
   assign great     = !result_q[WIDTH-1] && (result_q != '0);
   assign overflow  = ovf_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed vector table plus handshake, kill and reset sequences for alu_iter
module tb_alu_iter;
   import alu_iter_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [5:0]    alu_op;
   logic [W-1:0]  a, b, out;
   logic [4:0]    shamt;
   logic          kill, out_valid, out_ready;
   logic          zero, great, overflow, div_zero, busy;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] va;
      logic [31:0] vb;
      logic [4:0]  sh;
      logic [31:0] exp;
      logic        eovf;
      logic        edz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   alu_iter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .a(a), .b(b), .shamt(shamt), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready), .out(out),
      .zero(zero), .great(great), .overflow(overflow), .div_zero(div_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [5:0] op, input logic [31:0] va,
                      input logic [31:0] vb, input logic [4:0] sh, input logic [31:0] e,
                      input logic eo, input logic ed, input int lat);
      vec_t v;
      v.name = nm; v.op = op; v.va = va; v.vb = vb; v.sh = sh;
      v.exp = e; v.eovf = eo; v.edz = ed; v.lat = lat;
      vecs.push_back(v);
   endtask

   task automatic run(input vec_t v);
      int lat, bcnt;
      @(negedge clk);
      alu_op = v.op; a = v.va; b = v.vb; shamt = v.sh; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      // Scramble operands after acceptance: the result must not depend on them.
      a = ~v.va; b = ~v.vb; shamt = ~v.sh;
      lat = 1; bcnt = 0;
      while (1) begin
         if (busy) bcnt++;
         if (out_valid || lat >= 200) break;
         @(negedge clk);
         lat++;
      end
      chk({v.name, " latency"}, 64'(lat), 64'(v.lat));
      chk({v.name, " busy cycles"}, 64'(bcnt), 64'(v.lat - 1));
      chk({v.name, " out"}, 64'(out), 64'(v.exp));
      chk({v.name, " overflow"}, 64'(overflow), 64'(v.eovf));
      chk({v.name, " div_zero"}, 64'(div_zero), 64'(v.edz));
      chk({v.name, " zero"}, 64'(zero), 64'(v.exp == 32'h0));
      chk({v.name, " great"}, 64'(great), 64'(!v.exp[31] && v.exp != 32'h0));
      chk({v.name, " in_ready in DONE"}, 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({v.name, " back to idle"}, 64'({in_ready, out_valid}), 64'b10);
   endtask

   initial begin
      vec_t v;
      int   ov_seen;

      add("ADD ovf",   ALU_OP_ADD,   32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b0, 1);
      add("ADDU",      ALU_OP_ADDU,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b0, 1);
      add("SUB ovf",   ALU_OP_SUB,   32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 1);
      add("SUB neg",   ALU_OP_SUB,   32'h5,        32'h7,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1);
      add("AND",       ALU_OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1'b0, 1'b0, 1);
      add("OR",        ALU_OP_OR,    32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0, 1);
      add("XOR zero",  ALU_OP_XOR,   32'h1234,     32'h1234,     5'd0,  32'h0,        1'b0, 1'b0, 1);
      add("NOR",       ALU_OP_NOR,   32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1);
      add("SLL 31",    ALU_OP_SLL,   32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0, 1'b0, 1);
      add("SRA",       ALU_OP_SRA,   32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0, 1);
      add("SRL",       ALU_OP_SRL,   32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0, 1'b0, 1);
      add("ROTR 4",    ALU_OP_ROTR,  32'h0,        32'h12345678, 5'd4,  32'h81234567, 1'b0, 1'b0, 1);
      add("ROTR 0",    ALU_OP_ROTR,  32'h0,        32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1);
      add("ROTRV 8",   ALU_OP_ROTRV, 32'h8,        32'h12345678, 5'd3,  32'h78123456, 1'b0, 1'b0, 1);
      add("SRAV",      ALU_OP_SRAV,  32'h21,       32'hFFFFFFF0, 5'd9,  32'hFFFFFFF8, 1'b0, 1'b0, 1);
      add("SLT",       ALU_OP_SLT,   32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0, 1);
      add("SLTU",      ALU_OP_SLTU,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1'b0, 1);
      add("MUL",       ALU_OP_MUL,   32'hFFFFFFFD, 32'h7,        5'd0,  32'hFFFFFFEB, 1'b0, 1'b0, 33);
      add("MUH",       ALU_OP_MUH,   32'hFFFFFFFF, 32'h2,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 33);
      add("MULU",      ALU_OP_MULU,  32'hFFFFFFFF, 32'h2,        5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 33);
      add("MUHU",      ALU_OP_MUHU,  32'hFFFFFFFF, 32'h2,        5'd0,  32'h1,        1'b0, 1'b0, 33);
      add("DIV",       ALU_OP_DIV,   32'hFFFFFFF9, 32'h2,        5'd0,  32'hFFFFFFFD, 1'b0, 1'b0, 33);
      add("MOD",       ALU_OP_MOD,   32'hFFFFFFF9, 32'h2,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 33);
      add("DIV negb",  ALU_OP_DIV,   32'h7,        32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 1'b0, 1'b0, 33);
      add("MOD negb",  ALU_OP_MOD,   32'h7,        32'hFFFFFFFE, 5'd0,  32'h1,        1'b0, 1'b0, 33);
      add("DIVU",      ALU_OP_DIVU,  32'd100,      32'd7,        5'd0,  32'd14,       1'b0, 1'b0, 33);
      add("MODU",      ALU_OP_MODU,  32'd100,      32'd7,        5'd0,  32'd2,        1'b0, 1'b0, 33);
      add("DIV by 0",  ALU_OP_DIV,   32'h5,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1);
      add("MOD by 0",  ALU_OP_MOD,   32'h5,        32'h0,        5'd0,  32'h5,        1'b0, 1'b1, 1);
      add("DIVU by 0", ALU_OP_DIVU,  32'h9,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b1, 1);
      add("DIV ovf",   ALU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b1, 1'b0, 33);
      add("MOD ovf",   ALU_OP_MOD,   32'h80000000, 32'hFFFFFFFF, 5'd0,  32'h0,        1'b1, 1'b0, 33);
      add("bad op",    6'h3F,        32'h1,        32'h1,        5'd0,  32'h0,        1'b0, 1'b0, 1);

      rst_n = 1'b0; in_valid = 1'b0; alu_op = '0; a = '0; b = '0; shamt = '0;
      kill = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset out", 64'(out), 64'h0);
      chk("reset flags", 64'({out_valid, zero, great, overflow, div_zero, busy}), 64'b010000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) run(vecs[i]);

      // Result held while the consumer stalls; requests during DONE are ignored.
      @(negedge clk);
      alu_op = ALU_OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      @(negedge clk);
      alu_op = ALU_OP_SUB; a = 32'd100; b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         chk("hold out", 64'(out), 64'd7);
         chk("hold valid/ready", 64'({out_valid, in_ready}), 64'b10);
         if (i < 4) @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold release idle", 64'({out_valid, in_ready}), 64'b01);

      // Kill at CALC cycle 10 drops the operation.
      alu_op = ALU_OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("kill busy before", 64'(busy), 64'd1);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk("kill idle", 64'({out_valid, in_ready, busy}), 64'b010);
      ov_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      chk("kill no out_valid", 64'(ov_seen), 64'd0);

      // Kill in IDLE does not block acceptance.
      alu_op = ALU_OP_ADD; a = 32'd1; b = 32'd2; in_valid = 1'b1; kill = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; kill = 1'b0;
      chk("idle kill accepted", 64'({out_valid, out}), {31'd0, 1'b1, 32'd3});
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Asynchronous reset between edges mid-DIVU.
      alu_op = ALU_OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out", 64'(out), 64'h0);
      chk("async rst state", 64'({in_ready, busy, out_valid, zero}), 64'b1001);
      @(negedge clk);
      rst_n = 1'b1;
      v.name = "DIVU after reset"; v.op = ALU_OP_DIVU; v.va = 32'd100; v.vb = 32'd7;
      v.sh = 5'd0; v.exp = 32'd14; v.eovf = 1'b0; v.edz = 1'b0; v.lat = 33;
      run(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
